// File: rtl/stream_nasti_mover_ctrl.sv
// Round-robin command scheduler that shares one stream-to-NASTI mover between NUM_REQ DMA requesters.
// Optional watchdog is compiled in with `define STREAM_MOVER_CTRL_WDT_EN.
module stream_nasti_mover_ctrl #(
  parameter int ADDR_WIDTH    = 64,
  parameter int DATA_WIDTH    = 64,
  parameter int NUM_REQ       = 4,
  parameter int TIMEOUT_WIDTH = 20,
  localparam int ADDR_SHIFT   = $clog2(DATA_WIDTH / 8),
  localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CMD_W        = ADDR_WIDTH - ADDR_SHIFT + 24
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*16-1:0]         req_length,
  output logic                          mv_r_valid,
  input  logic                          mv_r_ready,
  output logic                          cmd_valid,
  output logic [CMD_W-1:0]              cmd_data,
  input  logic                          cmd_ready,
  output logic                          done_valid,
  output logic [ID_W-1:0]               done_id,
  output logic [1:0]                    done_status,
  output logic                          busy,
  output logic                          timeout
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    CMD   = 3'd2,
    BUSY  = 3'd3,
    PARK  = 3'd4,
    HALT  = 3'd5
  } state_t;

  state_t                          state_r, state_nxt_s;
  logic [ID_W-1:0]                 last_grant_r, cur_id_r;
  logic [ID_W-1:0]                 grant_id_s, scan_id_s, done_id_s;
  logic                            grant_found_s, take_s, done_set_s, wdt_fire_s;
  logic                            unused_addr_s;
  logic [1:0]                      done_status_s;
  logic [ADDR_WIDTH-ADDR_SHIFT-1:0] sel_addr_s;
  logic [15:0]                     sel_len_s;
  logic [CMD_W-1:0]                cmd_data_r;
  logic                            done_valid_r;
  logic [ID_W-1:0]                 done_id_r;
  logic [1:0]                      done_status_r;

  // Round-robin scan: first valid requester after last_grant, wrapping.
  always_comb begin
    grant_found_s = 1'b0;
    grant_id_s    = '0;
    scan_id_s     = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      scan_id_s = ID_W'((int'(last_grant_r) + off) % NUM_REQ);
      if (!grant_found_s && req_valid[scan_id_s]) begin
        grant_found_s = 1'b1;
        grant_id_s    = scan_id_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Payload mux for the winning requester; sub-beat address bits are dropped.
  always_comb begin
    sel_addr_s    = '0;
    sel_len_s     = 16'd0;
    unused_addr_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      unused_addr_s = unused_addr_s ^ (^req_addr[i*ADDR_WIDTH +: ADDR_SHIFT]);
      if (grant_id_s == ID_W'(i)) begin
        sel_addr_s = req_addr[i*ADDR_WIDTH+ADDR_SHIFT +: ADDR_WIDTH-ADDR_SHIFT];
        sel_len_s  = req_length[i*16 +: 16];
      end else begin
        sel_len_s  = sel_len_s;
      end
    end
  end

  assign take_s     = grant_found_s && ((state_r == IDLE) || (state_r == PARK));
  assign req_ready  = take_s ? (NUM_REQ'(1) << grant_id_s) : '0;
  assign busy       = (state_r == START) || (state_r == CMD) || (state_r == BUSY);
  assign mv_r_valid = (state_r == START);
  assign cmd_valid  = (state_r == CMD);
  assign cmd_data   = cmd_data_r;
  assign done_valid = done_valid_r;
  assign done_id    = done_id_r;
  assign done_status = done_status_r;

`ifdef STREAM_MOVER_CTRL_WDT_EN
  logic [TIMEOUT_WIDTH-1:0] wdt_cnt_r;
  logic                     timeout_r;

  assign wdt_fire_s = busy && (&wdt_cnt_r);
  assign timeout    = timeout_r;

  // Watchdog restarts with every accepted job so a long PARK never leaks into the next one.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wdt_cnt_r <= '0;
      timeout_r <= 1'b0;
    end else begin
      if (take_s) begin
        wdt_cnt_r <= '0;
      end else if (busy) begin
        wdt_cnt_r <= wdt_cnt_r + TIMEOUT_WIDTH'(1);
      end
      if (wdt_fire_s) begin
        timeout_r <= 1'b1;
      end
    end
  end
`else
  localparam int unused_timeout_width = TIMEOUT_WIDTH;
  assign wdt_fire_s = 1'b0;
  assign timeout    = 1'b0;
`endif

  // Next-state and completion decode.
  always_comb begin
    state_nxt_s   = state_r;
    done_set_s    = 1'b0;
    done_status_s = 2'd0;
    done_id_s     = cur_id_r;
    if (wdt_fire_s) begin
      state_nxt_s   = HALT;
      done_set_s    = 1'b1;
      done_status_s = 2'd3;
    end else begin
      case (state_r)
        IDLE, PARK: begin
          if (take_s && (sel_len_s == 16'd0)) begin
            done_set_s    = 1'b1;
            done_status_s = 2'd2;
            done_id_s     = grant_id_s;
          end else if (take_s) begin
            // From PARK the mover already waits in COMMAND, so skip the start handshake.
            state_nxt_s = (state_r == IDLE) ? START : CMD;
          end else begin
            state_nxt_s = state_r;
          end
        end
        START: state_nxt_s = mv_r_ready ? CMD : START;
        CMD:   state_nxt_s = cmd_ready ? BUSY : CMD;
        BUSY: begin
          if (mv_r_ready) begin
            state_nxt_s   = IDLE;
            done_set_s    = 1'b1;
            done_status_s = 2'd1;
          end else if (cmd_ready) begin
            state_nxt_s   = PARK;
            done_set_s    = 1'b1;
            done_status_s = 2'd0;
          end else begin
            state_nxt_s   = BUSY;
          end
        end
        HALT:    state_nxt_s = HALT;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Grant bookkeeping, command word and completion report.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      last_grant_r  <= ID_W'(NUM_REQ - 1);
      cur_id_r      <= '0;
      cmd_data_r    <= '0;
      done_valid_r  <= 1'b0;
      done_id_r     <= '0;
      done_status_r <= 2'd0;
    end else begin
      done_valid_r <= done_set_s;
      if (done_set_s) begin
        done_id_r     <= done_id_s;
        done_status_r <= done_status_s;
      end
      if (take_s) begin
        last_grant_r <= grant_id_s;
        cur_id_r     <= grant_id_s;
        cmd_data_r   <= {sel_addr_s, sel_len_s, 8'h00};
      end
    end
  end

endmodule

// File: tb/tb_stream_nasti_mover_ctrl.sv
// Self-checking bench for stream_nasti_mover_ctrl: bench-driven mover handshakes plus a round-robin reference model.
// Watchdog scenario is compiled only with STREAM_MOVER_CTRL_WDT_EN.
module tb_stream_nasti_mover_ctrl;
  localparam int NR = 4;
  localparam int AW = 64;
  localparam int CW = AW - 3 + 24;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR*16-1:0] req_length;
  logic            mv_r_valid, cmd_valid, done_valid, busy, timeout;
  logic            mv_r_ready = 1'b1;
  logic            cmd_ready = 1'b0;
  logic [CW-1:0]   cmd_data;
  logic [1:0]      done_id, done_status;

  logic [AW-1:0]   addr_arr [NR];
  logic [15:0]     len_arr [NR];
  int              n_checks = 0;
  int              n_fail = 0;
  int              last_g = NR - 1;
  bit              parked = 1'b0;

  always #5 aclk = ~aclk;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW]   = addr_arr[i];
      req_length[i*16 +: 16] = len_arr[i];
    end
  end

  stream_nasti_mover_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(64), .NUM_REQ(NR), .TIMEOUT_WIDTH(4)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_length(req_length),
    .mv_r_valid(mv_r_valid), .mv_r_ready(mv_r_ready),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .done_valid(done_valid), .done_id(done_id), .done_status(done_status),
    .busy(busy), .timeout(timeout)
  );

  // Reference arbitration: first valid index after last, wrapping; -1 if none.
  function automatic int rr_pick(input int last, input logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++) begin
      if (v[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0; req_valid = '0; mv_r_ready = 1'b1; cmd_ready = 1'b0;
    step(); step();
    aresetn = 1'b1;
    last_g = NR - 1; parked = 1'b0;
  endtask

  // One job from grant to completion; gid returns the id the DUT actually granted.
  task automatic do_job(input bit drop, input int end_kind, output int gid);
    logic [NR-1:0] exp_rdy;
    logic [CW-1:0] exp_cmd;
    logic [1:0]    exp_st;
    int            mid, d;
    #1;
    mid = rr_pick(last_g, req_valid);
    exp_rdy = '0;
    if (mid >= 0) exp_rdy[mid] = 1'b1;
    gid = -1;
    for (int b = 0; b < NR; b++) if (req_ready[b]) gid = b;
    n_checks++;
    if (req_ready !== exp_rdy) begin
      n_fail++; $display("FAIL grant: req_ready=%b expected %b", req_ready, exp_rdy);
    end
    if (mid < 0) return;
    exp_cmd = {addr_arr[mid][AW-1:3], len_arr[mid], 8'h00};
    step();
    last_g = mid;
    if (drop) req_valid[mid] = 1'b0;
    if (len_arr[mid] == 16'd0) begin
      n_checks++;
      if ({done_valid, done_id, done_status, mv_r_valid, cmd_valid, busy} !== {1'b1, 2'(mid), 2'd2, 3'b000}) begin
        n_fail++; $display("FAIL zero_len_done: v/id/st/rv/cv/busy=%b/%0d/%0d/%b/%b/%b expected 1/%0d/2/0/0/0",
                           done_valid, done_id, done_status, mv_r_valid, cmd_valid, busy, mid);
      end
      return;
    end
    if (!parked) begin
      n_checks++;
      if ({mv_r_valid, cmd_valid, busy, done_valid} !== 4'b1010) begin
        n_fail++; $display("FAIL start: rv/cv/busy/done=%b%b%b%b expected 1010", mv_r_valid, cmd_valid, busy, done_valid);
      end
      step();
      mv_r_ready = 1'b0; cmd_ready = 1'b0;
      d = $urandom_range(0, 2);
      for (int w = 0; w <= d; w++) begin
        n_checks++;
        if ({mv_r_valid, cmd_valid} !== 2'b01 || cmd_data !== exp_cmd) begin
          n_fail++; $display("FAIL cmd_after_start: rv/cv=%b%b data=%h expected 01 data=%h", mv_r_valid, cmd_valid, cmd_data, exp_cmd);
        end
        if (w < d) step();
      end
      cmd_ready = 1'b1;
      step();
    end else begin
      n_checks++;
      if ({mv_r_valid, cmd_valid, busy, done_valid} !== 4'b0110 || cmd_data !== exp_cmd) begin
        n_fail++; $display("FAIL cmd_from_park: rv/cv/busy/done=%b%b%b%b data=%h expected 0110 data=%h",
                           mv_r_valid, cmd_valid, busy, done_valid, cmd_data, exp_cmd);
      end
      step();
    end
    cmd_ready = 1'b0; mv_r_ready = 1'b0;
    d = $urandom_range(1, 4);
    repeat (d) begin
      n_checks++;
      if ({mv_r_valid, cmd_valid, busy, done_valid} !== 4'b0010 || cmd_data !== exp_cmd) begin
        n_fail++; $display("FAIL busy_hold: rv/cv/busy/done=%b%b%b%b data=%h expected 0010 data=%h",
                           mv_r_valid, cmd_valid, busy, done_valid, cmd_data, exp_cmd);
      end
      step();
    end
    case (end_kind)
      0:       begin cmd_ready = 1'b1; exp_st = 2'd0; end
      1:       begin mv_r_ready = 1'b1; exp_st = 2'd1; end
      default: begin cmd_ready = 1'b1; mv_r_ready = 1'b1; exp_st = 2'd1; end
    endcase
    step();
    n_checks++;
    if ({done_valid, done_id, done_status, busy} !== {1'b1, 2'(mid), exp_st, 1'b0}) begin
      n_fail++; $display("FAIL completion: v/id/st/busy=%b/%0d/%0d/%b expected 1/%0d/%0d/0",
                         done_valid, done_id, done_status, busy, mid, exp_st);
    end
    parked = (end_kind == 0);
    if (end_kind != 0) begin mv_r_ready = 1'b1; cmd_ready = 1'b0; end
  endtask

  task automatic test_reset();
    aresetn = 1'b0; req_valid = '0; mv_r_ready = 1'b1; cmd_ready = 1'b0;
    step();
    n_checks++;
    if ({req_ready, mv_r_valid, cmd_valid, done_valid, busy, timeout} !== '0) begin
      n_fail++; $display("FAIL reset_ctrl: rdy=%b rv=%b cv=%b dv=%b busy=%b to=%b expected all 0",
                         req_ready, mv_r_valid, cmd_valid, done_valid, busy, timeout);
    end
    n_checks++;
    if ({cmd_data, done_id, done_status} !== '0) begin
      n_fail++; $display("FAIL reset_data: cmd=%h id=%0d st=%0d expected 0", cmd_data, done_id, done_status);
    end
    aresetn = 1'b1; last_g = NR - 1; parked = 1'b0;
    req_valid = 4'hF;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL reset_first_grant: req_ready=%b expected 0001", req_ready);
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_single_job();
    int gid;
    addr_arr[0] = 64'h1000; len_arr[0] = 16'd8;
    req_valid = 4'b0001;
    do_job(1'b1, 0, gid);
    n_checks++;
    if (gid !== 0 || cmd_data[CW-1:24] !== 61'h200 || cmd_data[23:8] !== 16'd8 || cmd_data[7:0] !== 8'h00) begin
      n_fail++; $display("FAIL single_job: id=%0d cmd=%h expected id 0 addr 200 len 8", gid, cmd_data);
    end
  endtask

  task automatic test_park_regrant();
    int gid;
    addr_arr[2] = {$urandom, $urandom}; len_arr[2] = 16'd4;
    req_valid = 4'b0100;
    do_job(1'b1, 0, gid);
    n_checks++;
    if (gid !== 2) begin n_fail++; $display("FAIL park_grant_id: got %0d expected 2", gid); end
  endtask

  task automatic test_round_robin();
    int gid, prev;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < NR; i++) begin
      addr_arr[i] = {$urandom, $urandom}; len_arr[i] = 16'($urandom_range(1, 300));
    end
    req_valid = 4'hF; prev = -1;
    for (int j = 0; j < 5; j++) begin
      do_job(1'b0, 0, gid);
      n_checks++;
      if (gid !== exp_order[j] || gid == prev) begin
        n_fail++; $display("FAIL rr_order: job %0d granted %0d expected %0d (prev %0d)", j, gid, exp_order[j], prev);
      end
      prev = gid;
    end
    req_valid = '0;
  endtask

  task automatic test_tlast_both();
    int gid;
    addr_arr[0] = {$urandom, $urandom}; len_arr[0] = 16'd5;
    req_valid = 4'b0001;
    do_job(1'b1, 2, gid);
    addr_arr[1] = {$urandom, $urandom}; len_arr[1] = 16'd3;
    req_valid = 4'b0010;
    do_job(1'b1, 1, gid);
  endtask

  task automatic test_zero_length();
    int g1, g2, g3, g4;
    addr_arr[1] = {$urandom, $urandom}; len_arr[1] = 16'd0;
    req_valid = 4'b0010;
    do_job(1'b1, 0, g1);
    repeat (3) begin
      step();
      n_checks++;
      if ({done_valid, mv_r_valid, cmd_valid, busy} !== 4'b0000) begin
        n_fail++; $display("FAIL zero_len_quiet: dv/rv/cv/busy=%b%b%b%b expected 0000", done_valid, mv_r_valid, cmd_valid, busy);
      end
    end
    len_arr[3] = 16'd0;
    req_valid = 4'b1010;
    do_job(1'b0, 0, g1);
    do_job(1'b0, 0, g2);
    n_checks++;
    if (g1 == g2 || g1 < 0 || g2 < 0) begin
      n_fail++; $display("FAIL zero_len_rotate: grants %0d then %0d expected distinct", g1, g2);
    end
    req_valid = 4'b0010;
    do_job(1'b0, 0, g3);
    do_job(1'b0, 0, g4);
    n_checks++;
    if (g3 !== 1 || g4 !== 1) begin
      n_fail++; $display("FAIL zero_len_sole: grants %0d then %0d expected 1 and 1", g3, g4);
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_reset_midjob();
    int gid;
    do_reset();
    addr_arr[1] = {$urandom, $urandom}; len_arr[1] = 16'd20;
    req_valid = 4'b0010;
    step(); step();
    mv_r_ready = 1'b0; cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL midjob_busy: busy=%b expected 1", busy); end
    aresetn = 1'b0; req_valid = '0;
    #1;
    n_checks++;
    if ({busy, done_valid, mv_r_valid, cmd_valid} !== 4'b0000) begin
      n_fail++; $display("FAIL midjob_reset: busy/dv/rv/cv=%b%b%b%b expected 0000", busy, done_valid, mv_r_valid, cmd_valid);
    end
    mv_r_ready = 1'b1;
    step();
    n_checks++;
    if (done_valid !== 1'b0) begin n_fail++; $display("FAIL midjob_no_done: done_valid=%b expected 0", done_valid); end
    aresetn = 1'b1; last_g = NR - 1; parked = 1'b0;
    addr_arr[0] = {$urandom, $urandom}; len_arr[0] = 16'd7;
    req_valid = 4'b0011;
    do_job(1'b1, 1, gid);
    n_checks++;
    if (gid !== 0) begin n_fail++; $display("FAIL midjob_regrant: got %0d expected 0", gid); end
    req_valid = '0;
  endtask

  task automatic test_random();
    int gid;
    for (int j = 0; j < 25; j++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i]) begin
          addr_arr[i] = {$urandom, $urandom};
          len_arr[i]  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
        end
      end
      if (req_valid == '0 || $urandom_range(0, 2) == 0) req_valid = req_valid | 4'($urandom_range(1, 15));
      do_job(1'($urandom_range(0, 1)), $urandom_range(0, 2), gid);
    end
    req_valid = '0;
    step();
  endtask

`ifdef STREAM_MOVER_CTRL_WDT_EN
  task automatic test_watchdog();
    int k;
    do_reset();
    addr_arr[0] = {$urandom, $urandom}; len_arr[0] = 16'd5;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    step();
    mv_r_ready = 1'b0; cmd_ready = 1'b0;
    k = 1;
    while (!done_valid && k < 40) begin step(); k++; end
    n_checks++;
    if (k !== 16 || done_status !== 2'd3 || done_id !== 2'd0 || timeout !== 1'b1) begin
      n_fail++; $display("FAIL watchdog: cycles=%0d st=%0d id=%0d to=%b expected 16/3/0/1", k, done_status, done_id, timeout);
    end
    req_valid = 4'hF;
    repeat (3) begin
      #1;
      n_checks++;
      if (req_ready !== '0 || mv_r_valid !== 1'b0) begin
        n_fail++; $display("FAIL halt_grant: req_ready=%b rv=%b expected 0000/0", req_ready, mv_r_valid);
      end
      step();
    end
    do_reset();
    n_checks++;
    if (timeout !== 1'b0) begin n_fail++; $display("FAIL watchdog_clear: timeout=%b expected 0", timeout); end
  endtask
`endif

  initial begin
    for (int i = 0; i < NR; i++) begin addr_arr[i] = '0; len_arr[i] = 16'd0; end
    test_reset();
    test_single_job();
    test_park_regrant();
    test_round_robin();
    test_tlast_both();
    test_zero_length();
    test_reset_midjob();
    test_random();
`ifdef STREAM_MOVER_CTRL_WDT_EN
    test_watchdog();
`else
    n_checks++;
    if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_tied: timeout=%b expected 0", timeout); end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL sim_time_limit: run exceeded time budget");
    $fatal(1);
  end

endmodule
